// File: rtl/registro_universal.sv
// Bidirectional universal shift register: parallel load, shift, rotate or hold,
// with a one-cycle flag after every N completed serial shifts.
module registro_universal #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enb,
    input  logic [1:0]   modo,
    input  logic         dir,
    input  logic         s_in,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         s_der,
    output logic         s_izq,
    output logic         lleno
);

    localparam int            CW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(N - 1);
    localparam logic [1:0]    MODO_SHIFT = 2'b00;
    localparam logic [1:0]    MODO_ROT   = 2'b01;
    localparam logic [1:0]    MODO_LOAD  = 2'b10;

    logic [N-1:0]  q_r;
    logic [N-1:0]  q_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          lleno_r;
    logic          lleno_next_s;

    // Next-state selection; lleno defaults low so a pulse never outlasts one edge.
    always_comb begin
        q_next_s     = q_r;
        cnt_next_s   = cnt_r;
        lleno_next_s = 1'b0;
        if (enb) begin
            case (modo)
                MODO_SHIFT: begin
                    if (dir) begin
                        q_next_s = {q_r[N-2:0], s_in};
                    end else begin
                        q_next_s = {s_in, q_r[N-1:1]};
                    end
                    if (cnt_r == CNT_MAX) begin
                        cnt_next_s   = {CW{1'b0}};
                        lleno_next_s = 1'b1;
                    end else begin
                        cnt_next_s = cnt_r + CW'(1);
                    end
                end
                MODO_ROT: begin
                    if (dir) begin
                        q_next_s = {q_r[N-2:0], q_r[N-1]};
                    end else begin
                        q_next_s = {q_r[0], q_r[N-1:1]};
                    end
                end
                MODO_LOAD: begin
                    q_next_s   = d;
                    cnt_next_s = {CW{1'b0}};
                end
                default: begin
                    q_next_s   = q_r;
                    cnt_next_s = cnt_r;
                end
            endcase
        end else begin
            q_next_s   = q_r;
            cnt_next_s = cnt_r;
        end
    end

    // State registers with immediate clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r     <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
            lleno_r <= 1'b0;
        end else begin
            q_r     <= q_next_s;
            cnt_r   <= cnt_next_s;
            lleno_r <= lleno_next_s;
        end
    end

    // Edge bits come straight from the register so the selector sees a stable value.
    assign q     = q_r;
    assign s_der = q_r[0];
    assign s_izq = q_r[N-1];
    assign lleno = lleno_r;

endmodule

// File: doc/registro_universal.md
# registro_universal

Parameterised bidirectional universal shift register that feeds the serial-output selector stage. It holds an N-bit word that can be loaded in parallel, shifted, rotated or held. It exposes its edge bits as `s_der` and `s_izq`, which drive the selector's inputs of the same name. A shift counter flags each completed N-bit serial transfer.

## Interface
- `N`, default 4: register width; legal values ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enb`  in  1  clock enable; when 0, all state holds.
- `modo`  in  2  operation select (see Operation); same encoding drives the downstream selector.
- `dir`  in  1  direction: 0 = right (toward bit 0), 1 = left (toward bit N-1).
- `s_in`  in  1  serial input bit inserted on shift.
- `d`  in  N  parallel load data.
- `q`  out  N  register contents.
- `s_der`  out  1  `q[0]`: bit leaving on the next right shift.
- `s_izq`  out  1  `q[N-1]`: bit leaving on the next left shift.
- `lleno`  out  1  one-cycle pulse when N shifts have completed since the last load, reset or wrap.

## Operation
- Reset (`rst`=1, asynchronous, immediate): `q`=0, internal counter `cnt`=0, `lleno`=0. `s_der`=`s_izq`=0 as a consequence. Held while `rst`=1.
- When `enb`=1, on a rising edge, by `modo`:
  - `00` shift. With `dir`=0: q ← {s_in, q[N-1:1]}. With `dir`=1: q ← {q[N-2:0], s_in}. `cnt` increments.
  - `01` rotate. With `dir`=0: q ← {q[0], q[N-1:1]}. With `dir`=1: q ← {q[N-2:0], q[N-1]}. `cnt` unchanged.
  - `10` parallel load: q ← `d`; `cnt` ← 0.
  - `11` hold: q and `cnt` unchanged.
- `cnt` is ceil(log2(N)) bits wide and counts 0..N-1.
- On a shift edge with `cnt`=N-1, `cnt` wraps to 0 and `lleno` is registered to 1 for exactly that next cycle.
- On every other edge, `lleno` is registered to 0. This includes `enb`=0 edges, so a pulse is never stretched.
- `enb`=0: `q` and `cnt` hold regardless of `modo`, `dir`, `s_in` and `d`.
- Direction changes mid-transfer are legal. `cnt` counts shifts in either direction.
- Reset asserted mid-transfer discards partial progress. A full N further shifts are required before `lleno`.

## Timing
- `s_der`, `s_izq` and `q` are purely register-derived, with no combinational path from inputs. The downstream selector sees a stable bit for the whole cycle.
- Latency: load, shift and rotate are visible on `q` one edge after the inputs are sampled.
- `lleno` rises on the same edge that performs the Nth shift. It falls on the following edge.
- All inputs are sampled only at the rising edge of `clk`. `rst` is the only input that acts between edges.

## Test plan
- Reset: `rst`=1 at arbitrary time with `q`=1111 → `q`=0000, `s_der`=0, `s_izq`=0, `lleno`=0 immediately, without waiting for an edge.
- Load then shift right (N=4): load `d`=1011, then `modo`=00, `dir`=0, `s_in`=0 for 4 edges.
  - `q`: 1011 → 0101 → 0010 → 0001 → 0000.
  - `s_der` before each shift: 1, 1, 0, 1.
  - `lleno`=1 only in the cycle after the 4th shift.
- Shift left with `s_in`=1 from 0000, 4 edges: `q` = 0001, 0011, 0111, 1111; `s_izq`=1 after the 4th edge; `lleno` pulses once.
- Rotate: load 1001, `modo`=01.
  - `dir`=1 for 4 edges → 0011, 0110, 1100, 1001.
  - `dir`=0 for 1 edge → 1100.
  - `lleno` stays 0 throughout.
- Hold and enable: `modo`=11 for 3 edges, then `modo`=00 with `enb`=0 for 3 edges. `q` is unchanged throughout; a `lleno` pulse already high drops after one edge.
- Reset mid-transfer:
  - Load 1111, perform 2 shifts, assert `rst` between edges → `q`=0000 at once.
  - After release, 3 shifts give no `lleno`; the 4th shift gives the `lleno` pulse.
